// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4_pkg: definitions shared by the TDM receive path.
//   - slot count and slot-index width
//   - frame-alignment FSM state encoding
//   - helper that identifies the final slot of a frame
package tdm_demux4_pkg;

  localparam int TDM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    TDM_HUNT   = 1'b0,
    TDM_LOCKED = 1'b1
  } tdm_state_e;

  // True when the slot index addresses the last slot of a frame.
  function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
    return (slot == SLOT_W'(TDM_SLOTS - 1));
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: sample-stream and frame-output bundle of the TDM demux.
//   din/din_valid/frame_sync : serialized sample stream into the demux
//   ch_a..ch_d               : the four channels of the last complete frame
//   frame_valid              : one-cycle strobe when ch_a..ch_d update
//   locked / sync_err        : alignment status
// The master modport belongs to the stream source; slave to the demux.
interface tdm_demux4_if #(
  parameter int W = 1
);

  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] ch_a;
  logic [W-1:0] ch_b;
  logic [W-1:0] ch_c;
  logic [W-1:0] ch_d;
  logic         frame_valid;
  logic         locked;
  logic         sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch_a, ch_b, ch_c, ch_d, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_a, ch_b, ch_c, ch_d, frame_valid, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: 2-bit slot position within a TDM frame.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : return to slot 0 (loss of lock)
//   load_one  : a slot-0 sample was taken, next expected slot is 1
//   inc       : a slot 1..3 sample was taken, advance (3 wraps to 0)
//   slot      : current slot index
//   last_slot : slot index is 3
module tdm_slot_counter
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_one,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  logic [SLOT_W-1:0] slot_r;

  // Slot index register; clear outranks load, load outranks increment.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      slot_r <= 2'd0;
    end else if (load_one) begin
      slot_r <= 2'd1;
    end else if (inc) begin
      slot_r <= slot_r + 2'd1;
    end else begin
      slot_r <= slot_r;
    end
  end

  assign slot      = slot_r;
  assign last_slot = is_last_slot(slot_r);

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM receive demultiplexer with frame alignment.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of tdm_demux4_if (sample stream in, channels out)
// Samples of slots 0..2 are staged; the slot-3 sample loads all four
// channel registers at once so the outputs never show a partial frame.
// HUNT waits for frame_sync; LOCKED flywheels over up to MISS_LIMIT-1
// frames whose slot-0 sample lacks frame_sync before falling back to HUNT.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W          = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux4_if.slave   bus
);

  localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

  tdm_state_e        state_r;
  tdm_state_e        state_nx_s;
  logic [3:0]        miss_cnt_r;
  logic [3:0]        miss_nx_s;
  logic [W-1:0]      staging_r [3];
  logic [2:0]        st_we_s;
  logic              cnt_load_s;
  logic              cnt_inc_s;
  logic              cnt_clear_s;
  logic              frame_done_s;
  logic              sync_err_nx_s;
  logic [SLOT_W-1:0] slot_s;
  logic              last_slot_s;
  logic [W-1:0]      ch_a_r;
  logic [W-1:0]      ch_b_r;
  logic [W-1:0]      ch_c_r;
  logic [W-1:0]      ch_d_r;
  logic              frame_valid_r;
  logic              sync_err_r;

  tdm_slot_counter u_slot (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear_s),
    .load_one  (cnt_load_s),
    .inc       (cnt_inc_s),
    .slot      (slot_s),
    .last_slot (last_slot_s)
  );

  // FSM state and consecutive-missed-sync counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= TDM_HUNT;
      miss_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nx_s;
      miss_cnt_r <= miss_nx_s;
    end
  end

  // Next-state, staging write enables, slot-counter controls and strobes.
  always_comb begin
    state_nx_s    = state_r;
    miss_nx_s     = miss_cnt_r;
    st_we_s       = 3'b000;
    cnt_load_s    = 1'b0;
    cnt_inc_s     = 1'b0;
    cnt_clear_s   = 1'b0;
    frame_done_s  = 1'b0;
    sync_err_nx_s = 1'b0;
    case (state_r)
      TDM_HUNT: begin
        if (bus.din_valid && bus.frame_sync) begin
          st_we_s    = 3'b001;
          cnt_load_s = 1'b1;
          miss_nx_s  = 4'd0;
          state_nx_s = TDM_LOCKED;
        end else begin
          state_nx_s = TDM_HUNT;
        end
      end
      TDM_LOCKED: begin
        if (!bus.din_valid) begin
          state_nx_s = TDM_LOCKED;
        end else if (slot_s == 2'd0) begin
          if (bus.frame_sync) begin
            st_we_s    = 3'b001;
            cnt_load_s = 1'b1;
            miss_nx_s  = 4'd0;
          end else if ((miss_cnt_r + 4'd1) < MISS_LIM) begin
            // Flywheel: keep the frame, remember the missing sync.
            st_we_s    = 3'b001;
            cnt_load_s = 1'b1;
            miss_nx_s  = miss_cnt_r + 4'd1;
          end else begin
            // Too many missed syncs: drop this sample and rehunt.
            cnt_clear_s = 1'b1;
            miss_nx_s   = 4'd0;
            state_nx_s  = TDM_HUNT;
          end
        end else if (bus.frame_sync) begin
          // Sync in mid-frame: abandon the partial frame, realign here.
          sync_err_nx_s = 1'b1;
          st_we_s       = 3'b001;
          cnt_load_s    = 1'b1;
          miss_nx_s     = 4'd0;
        end else begin
          cnt_inc_s = 1'b1;
          if (last_slot_s) begin
            frame_done_s = 1'b1;
          end else begin
            st_we_s = 3'b001 << slot_s;
          end
        end
      end
      default: begin
        state_nx_s  = TDM_HUNT;
        cnt_clear_s = 1'b1;
        miss_nx_s   = 4'd0;
      end
    endcase
  end

  // Staging registers for slots 0..2 of the frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        staging_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (st_we_s[i]) begin
          staging_r[i] <= bus.din;
        end else begin
          staging_r[i] <= staging_r[i];
        end
      end
    end
  end

  // Channel outputs load as a whole frame; strobes last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_a_r        <= '0;
      ch_b_r        <= '0;
      ch_c_r        <= '0;
      ch_d_r        <= '0;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      frame_valid_r <= frame_done_s;
      sync_err_r    <= sync_err_nx_s;
      if (frame_done_s) begin
        ch_a_r <= staging_r[0];
        ch_b_r <= staging_r[1];
        ch_c_r <= staging_r[2];
        ch_d_r <= bus.din;
      end else begin
        ch_a_r <= ch_a_r;
        ch_b_r <= ch_b_r;
        ch_c_r <= ch_c_r;
        ch_d_r <= ch_d_r;
      end
    end
  end

  assign bus.ch_a        = ch_a_r;
  assign bus.ch_b        = ch_b_r;
  assign bus.ch_c        = ch_c_r;
  assign bus.ch_d        = ch_d_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.sync_err    = sync_err_r;
  assign bus.locked      = (state_r == TDM_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed, table-driven bench for tdm_demux4 (W=1,
// MISS_LIMIT=2). Each vector is driven on the falling edge and the
// outputs are compared 1 time unit after the following rising edge, so
// each row's expected values are the state produced by that row.
module tb_tdm_demux4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tdm_demux4_if #(.W(1)) bus ();

  tdm_demux4 #(.W(1), .MISS_LIMIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       dv;
    logic       din;
    logic       fs;
    logic       fv;
    logic [3:0] ch;   // {ch_a, ch_b, ch_c, ch_d}
    logic       lk;
    logic       se;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic dv, input logic d, input logic fs,
                     input logic fv, input logic [3:0] ch, input logic lk, input logic se);
    vec_t v;
    v.rst = r; v.dv = dv; v.din = d; v.fs = fs;
    v.fv = fv; v.ch = ch; v.lk = lk; v.se = se;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic dv, input logic d, input logic fs);
    @(negedge clk);
    rst            = r;
    bus.din_valid  = dv;
    bus.din        = d;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic fv, input logic [3:0] ch,
                           input logic lk, input logic se);
    chk("frame_valid", idx, {3'b000, bus.frame_valid}, {3'b000, fv});
    chk("channels",    idx, {bus.ch_a, bus.ch_b, bus.ch_c, bus.ch_d}, ch);
    chk("locked",      idx, {3'b000, bus.locked}, {3'b000, lk});
    chk("sync_err",    idx, {3'b000, bus.sync_err}, {3'b000, se});
  endtask

  initial begin
    int gaps[4];
    logic [3:0] gdata;
    int fv_count;

    bus.din_valid  = 1'b0;
    bus.din        = 1'b0;
    bus.frame_sync = 1'b0;

    //   rst dv din fs | fv ch       lk se
    // Reset, then synced frame 1,0,1,1
    add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 4'b1011, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 4'b1011, 1'b1, 1'b0);
    // Reset, three unsynced samples dropped in HUNT, then frame 0,1,1,0
    add(1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 4'b0110, 1'b1, 1'b0);
    // Sync on slot 2: sync_err, partial frame dropped, realign at 0,1,0,1
    add(1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 4'b0110, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0110, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1'b0, 4'b0110, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0110, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 4'b0110, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b1, 4'b0101, 1'b1, 1'b0);
    // Two frames without sync: first flywheels (1,1,1,0), second drops lock
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0101, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0101, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0101, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 4'b1110, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b1110, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 4'b1110, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b1110, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b1110, 1'b0, 1'b0);
    // Reset after slot 2, unsynced sample dropped, then frame 0,0,1,0
    add(1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 4'b1110, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b1110, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b1110, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 4'b0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1'b1, 4'b0010, 1'b1, 1'b0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].dv, vq[i].din, vq[i].fs);
      check_all(i, vq[i].fv, vq[i].ch, vq[i].lk, vq[i].se);
    end

    // Synced frame 1,1,0,1 with idle gaps before each slot; idle cycles
    // carry frame_sync=1 with din_valid=0, which must be ignored.
    gaps[0] = 0; gaps[1] = 5; gaps[2] = 0; gaps[3] = 3;
    gdata    = 4'b1101;
    fv_count = 0;
    for (int s = 0; s < 4; s++) begin
      for (int g = 0; g < gaps[s]; g++) begin
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        if (bus.frame_valid === 1'b1) fv_count++;
        check_all(100 + s * 10 + g, 1'b0, 4'b0010, 1'b1, 1'b0);
      end
      drive(1'b0, 1'b1, gdata[3 - s], (s == 0) ? 1'b1 : 1'b0);
      if (bus.frame_valid === 1'b1) fv_count++;
      if (s < 3) begin
        check_all(100 + s * 10 + 9, 1'b0, 4'b0010, 1'b1, 1'b0);
      end else begin
        check_all(139, 1'b1, 4'b1101, 1'b1, 1'b0);
      end
    end
    for (int g = 0; g < 2; g++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.frame_valid === 1'b1) fv_count++;
      check_all(140 + g, 1'b0, 4'b1101, 1'b1, 1'b0);
    end
    chk("gap_fv_count", 150, 4'(fv_count), 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Receive-side counterpart of the 4:1 channel mux. It takes a time-division-multiplexed sample stream, four slots per frame, with slot 0 marked by frame_sync. It steers each sample to its channel, then presents all four channels together, once per frame, with a frame_valid strobe. It also tracks frame alignment: hunts for sync, locks onto it, and flags misaligned or missing sync.

Parameters:
W, 1, sample/channel data width in bits.
MISS_LIMIT, 2, consecutive frames without frame_sync at slot 0 before lock is dropped (legal range 1..15).

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
din  input  W  serialized sample.
din_valid  input  1  din carries a sample this cycle.
frame_sync  input  1  qualifies the current sample as slot 0; ignored unless din_valid=1.
ch_a  output  W  slot 0 data of last complete frame.
ch_b  output  W  slot 1 data of last complete frame.
ch_c  output  W  slot 2 data of last complete frame.
ch_d  output  W  slot 3 data of last complete frame.
frame_valid  output  1  one-cycle pulse when ch_a..ch_d update.
locked  output  1  1 while the FSM is in LOCKED.
sync_err  output  1  one-cycle pulse on frame_sync at slot!=0.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - ch_a..ch_d = 0; frame_valid, locked, sync_err = 0.
  - slot = 0; miss_cnt = 0; staging registers cleared; state HUNT.
- Reset asserted mid-frame discards the partial frame. The first accepted sample after reset must carry frame_sync.
- "Accepted sample" means din_valid=1 on a clock edge while rst=0.
- FSM states: HUNT, LOCKED.
- HUNT:
  - Accepted sample without frame_sync: dropped.
  - Accepted sample with frame_sync: stored to staging[0]; slot<=1; miss_cnt<=0; go LOCKED.
  - locked becomes 1 on the same edge as the transition.
- LOCKED, accepted sample at slot 0:
  - With frame_sync: store to staging[0]; miss_cnt<=0; slot<=1.
  - Without frame_sync, miss_cnt+1 < MISS_LIMIT: store to staging[0] (frame accepted as flywheel); miss_cnt++; slot<=1.
  - Without frame_sync, miss_cnt+1 = MISS_LIMIT: sample dropped; go HUNT; locked<=0; slot<=0; miss_cnt<=0.
- LOCKED, accepted sample at slot 1..3 with frame_sync:
  - sync_err=1 on the next cycle, for one cycle.
  - Partial frame discarded, with no frame_valid.
  - Sample stored as slot 0; slot<=1; miss_cnt<=0; stay LOCKED.
- LOCKED, accepted sample at slot 1..3 without frame_sync: store to staging[slot]; slot<=slot+1, 2-bit wrap 3->0.
- Frame completion: accepting the slot 3 sample loads ch_a<=staging[0], ch_b<=staging[1], ch_c<=staging[2], ch_d<=din on that same edge.
  - frame_valid=1 for that following cycle only.
  - Latency is 1 clock from the slot-3 sample to outputs.
- ch_* hold their value between frames and are never partially updated.
- din_valid=0 cycles: no state change, any number allowed between slots. frame_valid and sync_err are 0.
- frame_valid and sync_err cannot assert in the same cycle.

Decomposition:
- Shared include tdm_defs.vh:
  - state encodings TDM_HUNT=1'b0, TDM_LOCKED=1'b1;
  - TDM_SLOTS=4;
  - slot width 2.
  - The same header serves the transmit-side framer.
- One natural sub-module: tdm_slot_counter. It is a 2-bit slot counter with load-to-1 on sync, increment on accept, clear on rst/unlock, and a last_slot output.
- Staging registers, miss counter and FSM stay in the top module.

Test Plan:
- Reset then 4 valid samples 1,0,1,1 with sync on the first (W=1) -> locked=1 after sample 1; frame_valid pulses 1 cycle after sample 4 with ch_a..ch_d=1,0,1,1.
- In HUNT, 3 samples without sync, then a synced frame 0,1,1,0 -> first 3 dropped; one frame_valid, outputs 0,1,1,0; no sync_err.
- Locked, sync asserted on slot 2 sample -> sync_err pulse, no frame_valid for the partial frame; the next 3 samples complete a frame starting at the resynced sample.
- Locked, MISS_LIMIT=2, two frames with no sync -> first frame still output (frame_valid=1); at slot 0 of the second, locked->0 and no further frame_valid until sync.
- Synced frame with din_valid gaps of 0..5 idle cycles between slots -> same outputs as gapless; frame_valid exactly once.
- rst asserted after slot 2 of a frame, then a full synced frame -> outputs 0 during and after reset; only the new frame's data appears; locked=0 immediately after the reset edge.
